d_cache: RTL
============

D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 Parameter INDEX_W, default 4: index width; the cache holds 2^INDEX_W lines, each one 16-bit word; tag = cpu_addr[15:INDEX_W].
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_addr  input  16  word address from the MEM stage.
REQ-005 cpu_wdata  input  16  store data.
REQ-006 cpu_we  input  1  store request.
REQ-007 cpu_re  input  1  load request.
REQ-008 cache_out  output  16  load data.
REQ-009 hit  output  1  the current request completes this cycle; 0 = stall the pipeline.
REQ-010 mem_req  output  1  backing-memory request.
REQ-011 mem_we  output  1  backing-memory write (1) or read (0).
REQ-012 mem_addr  output  16  backing-memory address.
REQ-013 mem_wdata  output  16  backing-memory write data.
REQ-014 mem_rdata  input  16  backing-memory read data, valid when mem_ack=1.
REQ-015 mem_ack  input  1  backing-memory completion, one-cycle pulse.
REQ-016 hit_cnt, miss_cnt  output  16 each  statistics counters (see Configuration).

Function
REQ-017 Organisation SHALL be direct-mapped, write-through and no-write-allocate, with per-line valid bit, tag and data.
REQ-018 The FSM SHALL have three states: IDLE, RD_WAIT and WR_WAIT.
REQ-019 When cpu_we and cpu_re are both 1, the request SHALL be treated as a store.
REQ-020 In IDLE with no request, hit SHALL be 1 and cache_out SHALL be 0.
REQ-021 Read hit (IDLE, valid and tag match): hit SHALL be 1 combinationally in the same cycle, cache_out SHALL equal the line data, and the state SHALL remain IDLE.
REQ-022 Read miss in IDLE: hit SHALL be 0; the next state SHALL be RD_WAIT; mem_addr SHALL be registered from cpu_addr; mem_we SHALL be 0.
REQ-023 In RD_WAIT: mem_req SHALL be 1 and hit SHALL be 0.
REQ-024 On mem_ack in RD_WAIT, the line SHALL be filled (data = mem_rdata, tag written, valid = 1) and the state SHALL return to IDLE; the still-held request then hits on the following cycle.
REQ-025 Store in IDLE: hit SHALL be 0; the next state SHALL be WR_WAIT; mem_addr and mem_wdata SHALL be registered from cpu_addr and cpu_wdata; mem_we SHALL be 1.
REQ-026 In WR_WAIT: mem_req SHALL be 1, and hit SHALL be 0 except in the mem_ack cycle, when hit SHALL be 1.
REQ-027 On mem_ack in WR_WAIT, the line SHALL be updated only if valid and tag match, and the state SHALL return to IDLE.
REQ-028 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from the first cycle of a wait state until mem_ack; mem_req SHALL be 0 in IDLE.
REQ-029 mem_ack outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-030 Changes on the cpu_* inputs during a wait state SHALL not alter the outstanding memory transaction.
REQ-031 Minimum latencies: read miss = 1 (detect) + N (memory wait, N >= 1) + 1 (hit cycle); store = 1 + N, with hit in the ack cycle.

Reset
REQ-032 While reset=0: state = IDLE, all valid bits = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, counters = 0; tag and data arrays need not be cleared.
REQ-033 Reset asserted mid-transaction SHALL drop mem_req immediately (asynchronously) and abandon the transaction; no line SHALL be filled.

Configuration
REQ-034 The macro DCACHE_STATS_EN SHALL control the statistics counters.
REQ-035 With DCACHE_STATS_EN defined: miss_cnt SHALL increment on each IDLE->RD_WAIT transition; hit_cnt SHALL increment on each read hit in IDLE not immediately preceded by RD_WAIT; both counters SHALL saturate at 16'hFFFF.
REQ-036 Without DCACHE_STATS_EN: hit_cnt = 0 and miss_cnt = 0 constantly, and no counter registers SHALL be synthesised.

Verification
REQ-037 After reset, read 16'h0013 with memory returning 16'hBEEF after 2 cycles -> hit=0 for 3 cycles, mem_req=1 for 2 cycles, then hit=1 with cache_out=16'hBEEF; miss_cnt=1, hit_cnt=0.
REQ-038 Read 16'h0013 again -> hit=1 in the same cycle, cache_out=16'hBEEF, mem_req=0; hit_cnt=1.
REQ-039 Store 16'h1234 to 16'h0013, then read 16'h0013 -> mem_we=1, mem_wdata=16'h1234 until ack, hit=1 in the ack cycle; the read then hits with cache_out=16'h1234.
REQ-040 Store to 16'h0023 (same index, different tag), then read 16'h0013 -> line not updated; the read hits with 16'h1234.
REQ-041 cpu_we=cpu_re=1 -> store behaviour (mem_we=1); stray mem_ack in IDLE -> no state change.
REQ-042 Reset pulse during RD_WAIT -> mem_req=0 at once; the next read of the same address misses; miss_cnt=0 after reset.

Source files
------------

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 16-bit word per line.
// Define DCACHE_STATS_EN to build the saturating hit/miss statistics counters.
module d_cache #(
  parameter int INDEX_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [15:0] cache_out,
  output logic        hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 16 - INDEX_W;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [15:0]        data_q [LINES];
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               start_rd;

  logic [INDEX_W-1:0] cpu_idx, mem_idx;
  logic [TAG_W-1:0]   cpu_tag, mem_tag;
  logic               lookup_hit, fill_en, update_en;

  assign cpu_idx    = cpu_addr[INDEX_W-1:0];
  assign cpu_tag    = cpu_addr[15:INDEX_W];
  assign mem_idx    = mem_addr_q[INDEX_W-1:0];
  assign mem_tag    = mem_addr_q[15:INDEX_W];
  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

  // Line writes are keyed off the latched memory address, never the live CPU inputs.
  assign fill_en   = (state_q == RD_WAIT) && mem_ack;
  assign update_en = (state_q == WR_WAIT) && mem_ack && valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

  always_comb begin
    state_d     = state_q;
    hit         = 1'b0;
    cache_out   = 16'h0000;
    start_rd    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          state_d     = WR_WAIT;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_we_d    = 1'b1;
        end else if (cpu_re) begin
          if (lookup_hit) begin
            hit       = 1'b1;
            cache_out = data_q[cpu_idx];
          end else begin
            state_d    = RD_WAIT;
            start_rd   = 1'b1;
            mem_addr_d = cpu_addr;
            mem_we_d   = 1'b0;
          end
        end else begin
          hit = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_ack) state_d = IDLE;
      end
      WR_WAIT: begin
        if (mem_ack) begin
          hit     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if (fill_en) valid_q[mem_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[mem_idx]  <= mem_tag;
      data_q[mem_idx] <= mem_rdata;
    end else if (update_en) begin
      data_q[mem_idx] <= mem_wdata_q;
    end
  end

  // Deriving mem_req from the state lets an asynchronous reset drop it at once.
  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        was_rd_q;
  logic        read_hit;

  // The hit that completes a refill is not counted, since that access was already a miss.
  assign read_hit = (state_q == IDLE) && !cpu_we && cpu_re && lookup_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
      was_rd_q   <= 1'b0;
    end else begin
      was_rd_q <= (state_q == RD_WAIT);
      if (start_rd && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'h0001;
      if (read_hit && !was_rd_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'h0001;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 16'h0000;
  assign miss_cnt = 16'h0000;
`endif

endmodule
